// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: EX-stage classification
// codes and the counter reset value.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    PS_NT_T  = 2'd0,
    PS_T_NT  = 2'd1,
    PS_NT_NT = 2'd2,
    PS_T_T   = 2'd3
  } pred_status_e;

  // Weakly-not-taken: the largest value whose MSB is still clear.
  function automatic logic [31:0] weak_nt_init(input int ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_update.sv
// Next-value logic for a saturating up/down counter; shared with the
// hazard unit's statistics.
module sat_counter_update #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != {CTR_BITS{1'b1}}) ctr_next = ctr + CTR_BITS'(1);
    end else begin
      if (ctr != {CTR_BITS{1'b0}}) ctr_next = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare branch predictor with tagged BTB: combinational IF-stage
// lookup, EX-stage classification and training.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 0,
  parameter int TAG_BITS = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     IF_valid,
  input  logic [XLEN-1:0]                          IF_pc,
  output logic [CTR_BITS-1:0]                      IF_prediction,
  output logic                                     IF_predict_taken,
  output logic [XLEN-1:0]                          IF_predicted_target,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] IF_ghr,
  input  logic                                     EX_Branch,
  input  logic [XLEN-1:0]                          EX_pc,
  input  logic [CTR_BITS-1:0]                      EX_branch_prediction,
  input  logic                                     EX_predict_taken,
  input  logic [XLEN-1:0]                          EX_predicted_target,
  input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] EX_ghr,
  input  logic                                     EX_branch_taken,
  input  logic [XLEN-1:0]                          EX_target,
  output logic [1:0]                               prediction_status,
  output logic                                     mispredict,
  output logic [31:0]                              branch_count,
  output logic [31:0]                              mispredict_count
);

  localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_nt_init(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_table  [DEPTH];
  logic [DEPTH-1:0]    btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [DEPTH];
  logic [XLEN-1:0]     btb_target [DEPTH];
  logic [GW-1:0]       ghr;

  logic [IDX_BITS-1:0] if_btb_idx, ex_btb_idx, if_hist, ex_hist;
  logic [IDX_BITS-1:0] if_ctr_idx, ex_ctr_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                btb_hit;
  logic [CTR_BITS-1:0] ex_ctr_next;
  pred_status_e        ex_status;

  assign if_btb_idx = IF_pc[IDX_BITS+1:2];
  assign ex_btb_idx = EX_pc[IDX_BITS+1:2];
  assign if_tag     = IF_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_tag     = EX_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Fetch hashes with the live history; training hashes with the history
  // the branch actually saw at fetch.
  always_comb begin
    if_hist = '0;
    ex_hist = '0;
    if (GHR_BITS > 0) begin
      if_hist[GW-1:0] = ghr;
      ex_hist[GW-1:0] = EX_ghr;
    end
  end

  assign if_ctr_idx = if_btb_idx ^ if_hist;
  assign ex_ctr_idx = ex_btb_idx ^ ex_hist;

  assign btb_hit             = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
  assign IF_prediction       = ctr_table[if_ctr_idx];
  assign IF_predict_taken    = IF_prediction[CTR_BITS-1] & btb_hit;
  assign IF_predicted_target = btb_hit ? btb_target[if_btb_idx] : '0;
  assign IF_ghr              = ghr;

  always_comb begin
    ex_status  = PS_NT_NT;
    mispredict = 1'b0;
    if (EX_Branch) begin
      unique case ({EX_predict_taken, EX_branch_taken})
        2'b01:   ex_status = PS_NT_T;
        2'b10:   ex_status = PS_T_NT;
        2'b00:   ex_status = PS_NT_NT;
        default: ex_status = PS_T_T;
      endcase
      mispredict = (ex_status == PS_NT_T) || (ex_status == PS_T_NT) ||
                   ((ex_status == PS_T_T) && (EX_predicted_target != EX_target));
    end
  end

  assign prediction_status = ex_status;

  sat_counter_update #(.CTR_BITS(CTR_BITS)) u_ctr_update (
    .ctr      (ctr_table[ex_ctr_idx]),
    .taken    (EX_branch_taken),
    .ctr_next (ex_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_table[i] <= CTR_INIT;
      btb_valid <= '0;
    end else if (EX_Branch) begin
      ctr_table[ex_ctr_idx] <= ex_ctr_next;
      if (EX_branch_taken) btb_valid[ex_btb_idx] <= 1'b1;
    end
  end

  // Tag and target payloads need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (rst_n && EX_Branch && EX_branch_taken) begin
      btb_tag[ex_btb_idx]    <= ex_tag;
      btb_target[ex_btb_idx] <= EX_target;
    end
  end

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GW:0] restore_shift, spec_shift;
      assign restore_shift = {EX_ghr, EX_branch_taken};
      assign spec_shift    = {ghr, IF_predict_taken};

      always_ff @(posedge clk) begin
        if (!rst_n)                      ghr <= '0;
        else if (mispredict)             ghr <= restore_shift[GW-1:0];
        else if (IF_valid && btb_hit)    ghr <= spec_shift[GW-1:0];
      end
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (EX_Branch && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

  // PC bits outside index/tag and the fetch-time counter copy are carried
  // for the pipeline but not consumed here.
  logic unused_ok;
  assign unused_ok = ^{IF_pc, EX_pc, EX_branch_prediction, IF_valid};

endmodule
